// File: rtl/key_pkg.sv
// key_pkg: shared types and helpers for the key scan arbiter.
//   state_t   : scan FSM state encoding (IDLE, SCAN, WAIT)
//   idx_width : bit width needed to hold 0..n-1, never less than 1
package key_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WAIT = 2'd2
  } state_t;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_tick_gen.sv
// key_tick_gen: free-running sample tick generator.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   tick : high for one cycle every CNT_NUM cycles (when the counter is at CNT_NUM-1)
module key_tick_gen
  import key_pkg::*;
#(
  parameter int CNT_NUM = 30
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int TW = idx_width(CNT_NUM);
  localparam logic [TW-1:0] LAST = TW'(CNT_NUM - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + TW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/key_scan_arbiter.sv
// key_scan_arbiter: one debounce engine shared across NUM_KEYS active-low
// buttons by round-robin scanning, with a serialized press/release event stream.
//   clk          : system clock
//   rst          : asynchronous active-high reset
//   key_n        : raw active-low buttons (asynchronous)
//   key_state    : debounced level per key (1 = released)
//   key_pulse    : one-cycle pulse when a press is accepted
//   evt_valid    : an event is presented on evt_key / evt_press
//   evt_key      : index of the key that changed
//   evt_press    : 1 = press, 0 = release
//   evt_ready    : consumer accepts the event this cycle
//   tick_overrun : sticky, a tick arrived while the previous one was still pending
//   dbg_state    : current scan FSM state
//
// Handshake: an event transfers on a cycle where evt_valid & evt_ready. Once
// evt_valid is raised, evt_key/evt_press stay stable until that transfer. A new
// event may be loaded in the same cycle the previous one transfers, so events
// can go back to back. Events are never dropped: the scan stalls in WAIT instead.
module key_scan_arbiter
  import key_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter int CNT_NUM        = 30,
  parameter int STABLE_SAMPLES = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_KEYS-1:0]           key_n,
  output logic [NUM_KEYS-1:0]           key_state,
  output logic [NUM_KEYS-1:0]           key_pulse,
  output logic                          evt_valid,
  output logic [idx_width(NUM_KEYS)-1:0] evt_key,
  output logic                          evt_press,
  input  logic                          evt_ready,
  output logic                          tick_overrun,
  output state_t                        dbg_state
);

  localparam int KW = idx_width(NUM_KEYS);
  localparam int CW = idx_width(STABLE_SAMPLES + 1);
  localparam logic [KW-1:0] LAST_IDX = KW'(NUM_KEYS - 1);
  localparam logic [CW-1:0] ACCEPT_CNT = CW'(STABLE_SAMPLES);

  logic [NUM_KEYS-1:0] ks_meta;
  logic [NUM_KEYS-1:0] ks;
  logic [CW-1:0]       cnt [NUM_KEYS];
  logic [KW-1:0]       idx;
  state_t              state;
  logic                tick;
  logic                tick_pending;

  logic                cur_ks;
  logic                differs;
  logic [CW-1:0]       cnt_inc;
  logic                accept;
  logic                consume;
  logic                stall;

  key_tick_gen #(
    .CNT_NUM(CNT_NUM)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Shared compare logic for the key currently addressed by idx.
  always_comb begin
    cur_ks  = ks[idx];
    differs = (ks[idx] != key_state[idx]);
    cnt_inc = cnt[idx] + CW'(1);
    accept  = (state == SCAN) && differs && (cnt_inc == ACCEPT_CNT);
    consume = evt_valid & evt_ready;
    // The event slot is busy and will not free up this cycle.
    stall   = accept && evt_valid && !evt_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ks_meta      <= '1;
      ks           <= '1;
      state        <= IDLE;
      idx          <= '0;
      key_state    <= '1;
      key_pulse    <= '0;
      evt_valid    <= 1'b0;
      evt_key      <= '0;
      evt_press    <= 1'b0;
      tick_pending <= 1'b0;
      tick_overrun <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      ks_meta   <= key_n;
      ks        <= ks_meta;
      key_pulse <= '0;

      if (consume) begin
        evt_valid <= 1'b0;
      end

      // A tick that lands while the previous one is still waiting is dropped.
      if (state == IDLE && tick_pending) begin
        tick_pending <= 1'b0;
      end
      if (tick) begin
        if (tick_pending) begin
          tick_overrun <= 1'b1;
        end else begin
          tick_pending <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          idx <= '0;
          if (tick_pending) begin
            state <= SCAN;
          end
        end

        SCAN: begin
          if (stall) begin
            // Hold idx and its count untouched; it is re-processed after WAIT.
            state <= WAIT;
          end else begin
            if (!differs) begin
              cnt[idx] <= '0;
            end else if (accept) begin
              cnt[idx]       <= '0;
              key_state[idx] <= cur_ks;
              key_pulse[idx] <= ~cur_ks;
              evt_valid      <= 1'b1;
              evt_key        <= idx;
              evt_press      <= ~cur_ks;
            end else begin
              cnt[idx] <= cnt_inc;
            end

            if (idx == LAST_IDX) begin
              state <= IDLE;
            end else begin
              idx <= idx + KW'(1);
            end
          end
        end

        WAIT: begin
          if (!evt_valid || evt_ready) begin
            state <= SCAN;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_key_scan_arbiter.sv
// tb_key_scan_arbiter: directed test of key_scan_arbiter with a scoreboard of
// expected events consumed by an independent monitor.
module tb_key_scan_arbiter;
  import key_pkg::*;

  localparam int NK = 4;
  localparam int CN = 30;
  localparam int SS = 3;
  localparam int KW = 2;
  localparam int W  = KW + 1;

  logic          clk;
  logic          rst;
  logic [NK-1:0] key_n;
  logic [NK-1:0] key_state;
  logic [NK-1:0] key_pulse;
  logic          evt_valid;
  logic [KW-1:0] evt_key;
  logic          evt_press;
  logic          evt_ready;
  logic          tick_overrun;
  state_t        dbg_state;

  key_scan_arbiter #(
    .NUM_KEYS       (NK),
    .CNT_NUM        (CN),
    .STABLE_SAMPLES (SS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_n        (key_n),
    .key_state    (key_state),
    .key_pulse    (key_pulse),
    .evt_valid    (evt_valid),
    .evt_key      (evt_key),
    .evt_press    (evt_press),
    .evt_ready    (evt_ready),
    .tick_overrun (tick_overrun),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            n_cmp = 0;
  int            n_err = 0;
  logic [W-1:0]  exp_q[$];
  int            evt_seen = 0;
  int            pulse_cnt[NK];
  logic          prev_valid;
  logic          prev_hs;
  logic [W-1:0]  prev_evt;
  logic [NK-1:0] prev_pulse;
  logic [NK-1:0] prev_state;
  logic [W-1:0]  mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      prev_evt   = '0;
      prev_pulse = '0;
      prev_state = '1;
    end else begin
      if (prev_valid && !prev_hs)
        check("evt_hold", {evt_valid, evt_key, evt_press}, {1'b1, prev_evt});
      if (evt_valid && evt_ready) begin
        evt_seen++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL evt_unexpected: got key %0d press %0d, expected no event", evt_key, evt_press);
        end else begin
          mon_e = exp_q.pop_front();
          check("evt", {evt_key, evt_press}, mon_e);
        end
      end
      for (int i = 0; i < NK; i++) begin
        if (key_pulse[i]) pulse_cnt[i]++;
        // A pulse must coincide with the 1->0 step of key_state and last one cycle.
        if (key_pulse[i] || (prev_state[i] && !key_state[i]))
          check("pulse_edge", {key_pulse[i], prev_pulse[i], prev_state[i], key_state[i]}, 4'b1010);
      end
      prev_valid = evt_valid;
      prev_hs    = evt_valid && evt_ready;
      prev_evt   = {evt_key, evt_press};
      prev_pulse = key_pulse;
      prev_state = key_state;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_level(input int k, input logic lvl, input int max_cyc, output int lat);
    lat = 0;
    while (key_state[k] !== lvl && lat < max_cyc) begin
      @(negedge clk);
      lat++;
    end
    check("wait_key_state", key_state[k], lvl);
  endtask

  task automatic wait_drain(input int max_cyc);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic wait_valid(input int max_cyc);
    int c;
    c = 0;
    while (evt_valid !== 1'b1 && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    check("wait_evt_valid", evt_valid, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_key_state"}, key_state, 4'hF);
    check({tag, "_key_pulse"}, key_pulse, 0);
    check({tag, "_evt_valid"}, evt_valid, 0);
    check({tag, "_evt_key"}, evt_key, 0);
    check({tag, "_evt_press"}, evt_press, 0);
    check({tag, "_tick_overrun"}, tick_overrun, 0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int base;
    for (int i = 0; i < NK; i++) pulse_cnt[i] = 0;
    rst       = 1'b1;
    key_n     = '1;
    evt_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #2 rst = 1'b0;

    // Idle with all keys released for 2 us.
    repeat (200) @(negedge clk);
    check("idle_key_state", key_state, 4'hF);
    check("idle_events", evt_seen, 0);
    check("idle_pulses", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], 0);
    check("idle_overrun", tick_overrun, 0);

    // Fast bounce on key 1: 50 ns toggles for 250 ns.
    for (int j = 0; j < 5; j++) begin
      key_n[1] = j[0];
      repeat (5) @(negedge clk);
    end
    key_n[1] = 1'b1;
    repeat (150) @(negedge clk);
    check("fast_bounce_state", key_state, 4'hF);
    check("fast_bounce_events", evt_seen, 0);
    check("fast_bounce_pulse", pulse_cnt[1], 0);

    // Slow bounce on key 1: alternating samples, three low but never consecutive.
    for (int j = 0; j < 6; j++) begin
      key_n[1] = j[0];
      repeat (CN) @(negedge clk);
    end
    key_n[1] = 1'b1;
    repeat (100) @(negedge clk);
    check("slow_bounce_state", key_state, 4'hF);
    check("slow_bounce_events", evt_seen, 0);
    check("slow_bounce_pulse", pulse_cnt[1], 0);

    // Clean press and release of key 2.
    key_n[2] = 1'b0;
    exp_q.push_back({2'd2, 1'b1});
    wait_level(2, 1'b0, 150, lat);
    check("press2_latency_ok", (lat >= 60 && lat <= 95), 1);
    repeat (45) @(negedge clk);
    check("press2_pulse_count", pulse_cnt[2], 1);
    check("press2_others", key_state, 4'b1011);
    wait_drain(20);
    key_n[2] = 1'b1;
    exp_q.push_back({2'd2, 1'b0});
    wait_level(2, 1'b1, 150, lat);
    check("release2_latency_ok", (lat >= 60 && lat <= 95), 1);
    repeat (45) @(negedge clk);
    check("release2_no_pulse", pulse_cnt[2], 1);
    wait_drain(20);

    // Keys 0 and 3 together with the consumer always ready.
    key_n[0] = 1'b0;
    key_n[3] = 1'b0;
    exp_q.push_back({2'd0, 1'b1});
    exp_q.push_back({2'd3, 1'b1});
    wait_level(0, 1'b0, 150, lat);
    wait_level(3, 1'b0, 10, lat);
    wait_drain(20);
    check("dual_pulse0", pulse_cnt[0], 1);
    check("dual_pulse3", pulse_cnt[3], 1);
    key_n[0] = 1'b1;
    key_n[3] = 1'b1;
    exp_q.push_back({2'd0, 1'b0});
    exp_q.push_back({2'd3, 1'b0});
    wait_level(3, 1'b1, 150, lat);
    wait_drain(20);
    check("pre_stall_overrun", tick_overrun, 0);

    // Same pair with the consumer stalled: scan must wait, ticks overrun.
    evt_ready = 1'b0;
    key_n[0]  = 1'b0;
    key_n[3]  = 1'b0;
    exp_q.push_back({2'd0, 1'b1});
    exp_q.push_back({2'd3, 1'b1});
    wait_valid(150);
    check("stall_first_key", {evt_key, evt_press}, {2'd0, 1'b1});
    repeat (5) @(negedge clk);
    check("stall_state_wait", dbg_state, WAIT);
    check("stall_key3_held", key_state[3], 1);
    repeat (70) @(negedge clk);
    check("stall_overrun", tick_overrun, 1);
    check("stall_still_key0", {evt_valid, evt_key}, {1'b1, 2'd0});
    check("stall_still_wait", dbg_state, WAIT);
    evt_ready = 1'b1;
    wait_drain(20);
    repeat (3) @(negedge clk);
    check("stall_key3_accepted", key_state[3], 0);
    check("overrun_sticky", tick_overrun, 1);
    key_n[0] = 1'b1;
    key_n[3] = 1'b1;
    exp_q.push_back({2'd0, 1'b0});
    exp_q.push_back({2'd3, 1'b0});
    wait_level(3, 1'b1, 150, lat);
    wait_drain(20);

    // Reset while an event is pending and the scan is in progress.
    evt_ready = 1'b0;
    key_n[1]  = 1'b0;
    wait_valid(150);
    check("rst_pre_evt_key", evt_key, 1);
    check("rst_pre_state_scan", dbg_state, SCAN);
    #2 rst = 1'b1;
    #1;
    check_reset_values("midscan_reset");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    evt_ready = 1'b1;
    base = pulse_cnt[1];
    exp_q.push_back({2'd1, 1'b1});
    wait_level(1, 1'b0, 150, lat);
    check("post_rst_latency_ok", (lat >= 60 && lat <= 95), 1);
    repeat (5) @(negedge clk);
    check("post_rst_pulse", pulse_cnt[1] - base, 1);
    wait_drain(20);
    key_n[1] = 1'b1;
    exp_q.push_back({2'd1, 1'b0});
    wait_level(1, 1'b1, 150, lat);
    wait_drain(20);

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_key_state", key_state, 4'hF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "time limit");
  end

endmodule
